// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_MUL   = 4'b1001,
        OP_MULHU = 4'b1010,
        OP_DIV   = 4'b1011,
        OP_SLT   = 4'b1100,
        OP_DIVU  = 4'b1101,
        OP_REM   = 4'b1110,
        OP_REMU  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } alu_state_e;

    function automatic logic is_iterative(alu_op_e op);
        return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_divide(alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(alu_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand request and result response handshakes of the sequential ALU.
interface alu_seq_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    ALUResult;

    modport master (
        output in_valid, SrcA, SrcB, Operation, out_ready,
        input  in_ready, out_valid, ALUResult
    );

    modport slave (
        input  in_valid, SrcA, SrcB, Operation, out_ready,
        output in_ready, out_valid, ALUResult
    );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier and restoring divider sharing one hi/lo/operand datapath.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    // hi: product high half / partial remainder; lo: multiplier / quotient shift register
    logic [W-1:0]     hi, lo, opnd;
    logic [W-1:0]     hi_nx, lo_nx, raw;
    logic [W:0]       sum, shifted, trial;
    logic [CNT_W-1:0] cnt;
    alu_op_e          op_q;
    logic             neg_q;

    logic             a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;

    assign a_neg = is_signed_div(op) & a[W-1];
    assign b_neg = is_signed_div(op) & b[W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hi_nx   = hi;
        lo_nx   = lo;
        sum     = '0;
        shifted = '0;
        trial   = '0;
        if (op_q inside {OP_MUL, OP_MULHU}) begin
            sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_nx = sum[W:1];
            lo_nx = {sum[0], lo[W-1:1]};
        end else begin
            shifted = {hi, lo[W-1]};
            trial   = shifted - {1'b0, opnd};
            if (!trial[W]) begin
                hi_nx = trial[W-1:0];
                lo_nx = {lo[W-2:0], 1'b1};
            end else begin
                hi_nx = shifted[W-1:0];
                lo_nx = {lo[W-2:0], 1'b0};
            end
        end
    end

    // Result reflects the step being taken now, so the top can register it on the final edge.
    always_comb begin
        raw = lo_nx;
        if (op_q inside {OP_MULHU, OP_REM, OP_REMU}) raw = hi_nx;
        result = neg_q ? -raw : raw;
    end

    assign done = (cnt == '0);

    // NOTE: datapath registers are reset too, so the counter reads 0 out of reset and state is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            cnt   <= '0;
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
        end else if (start) begin
            op_q <= op;
            cnt  <= CNT_W'(W - 1);
            hi   <= '0;
            if (is_divide(op)) begin
                lo    <= a_mag;
                opnd  <= b_mag;
                neg_q <= (op == OP_DIV) ? (a_neg ^ b_neg) : (op == OP_REM) ? a_neg : 1'b0;
            end else begin
                lo    <= b;
                opnd  <= a;
                neg_q <= 1'b0;
            end
        end else if (step) begin
            hi <= hi_nx;
            lo <= lo_nx;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshake FSM, single-cycle ops, divide special cases and the result register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_seq_if.slave  bus,
    output logic      busy
);
    localparam int W = DATA_WIDTH;

    alu_state_e               state, state_nx;
    logic [OPCODE_LENGTH-1:0] opcode;
    alu_op_e                  op;
    logic [W-1:0]             a, b, single_res, result_q, md_result, min_val;
    logic [SHAMT_W-1:0]       shamt;
    logic                     div_zero, div_ovf, special, go_busy, accept, md_done;

    assign opcode  = bus.Operation;
    assign op      = alu_op_e'(opcode[3:0]);
    assign a       = bus.SrcA;
    assign b       = bus.SrcB;
    assign shamt   = b[SHAMT_W-1:0];
    assign min_val = {1'b1, {(W-1){1'b0}}};

    // Divide-by-zero and MIN/-1 resolve in one cycle without touching the iterative unit.
    assign div_zero = (b == '0);
    assign div_ovf  = is_signed_div(op) && (a == min_val) && (b == '1);
    assign special  = is_divide(op) && (div_zero || div_ovf);
    assign go_busy  = is_iterative(op) && !special;
    assign accept   = (state == S_IDLE) && bus.in_valid && !flush;

    always_comb begin
        single_res = '0;
        case (op)
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_SLL:  single_res = a << shamt;
            OP_SRL:  single_res = a >> shamt;
            OP_XOR:  single_res = a ^ b;
            OP_SRA:  single_res = W'($signed(a) >>> shamt);
            OP_EQ:   single_res = {{(W-1){1'b0}}, (a == b)};
            OP_SLT:  single_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIV, OP_DIVU: single_res = div_zero ? '1 : min_val;
            OP_REM, OP_REMU: single_res = div_zero ? a : '0;
            default: single_res = '0;
        endcase
    end

    muldiv_iter #(.DATA_WIDTH(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && go_busy),
        .step   (state == S_BUSY),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nx = go_busy ? S_BUSY : S_DONE;
            S_BUSY:  if (md_done) state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        result_q <= '0;
        else if (flush)                    result_q <= '0;
        else if (accept && !go_busy)       result_q <= single_res;
        else if (state == S_BUSY && md_done) result_q <= md_result;
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.ALUResult = result_q;
    assign busy          = (state == S_BUSY);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, flush/reset/back-pressure sequences, random vs model.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy32, busy16;

    always #5 clk = ~clk;

    // Shared drive/monitor variables; sel steers them to the 32-bit (0) or 16-bit (1) instance.
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0, drv_rdy = 1'b0;
    logic [3:0]  drv_op = '0;
    logic [63:0] drv_a = '0, drv_b = '0;
    logic        mon_ready, mon_valid, mon_busy;
    logic [63:0] mon_res;

    alu_seq_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus32 ();
    alu_seq_if #(.DATA_WIDTH(16), .OPCODE_LENGTH(4)) bus16 ();

    assign bus32.in_valid  = drv_valid & ~sel;
    assign bus32.out_ready = drv_rdy & ~sel;
    assign bus32.SrcA      = drv_a[31:0];
    assign bus32.SrcB      = drv_b[31:0];
    assign bus32.Operation = drv_op;
    assign bus16.in_valid  = drv_valid & sel;
    assign bus16.out_ready = drv_rdy & sel;
    assign bus16.SrcA      = drv_a[15:0];
    assign bus16.SrcB      = drv_b[15:0];
    assign bus16.Operation = drv_op;

    assign mon_ready = sel ? bus16.in_ready  : bus32.in_ready;
    assign mon_valid = sel ? bus16.out_valid : bus32.out_valid;
    assign mon_busy  = sel ? busy16 : busy32;
    assign mon_res   = sel ? 64'(bus16.ALUResult) : 64'(bus32.ALUResult);

    alu_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave), .busy(busy32));
    alu_seq #(.DATA_WIDTH(16), .OPCODE_LENGTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus16.slave), .busy(busy16));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on masked/sign-extended values.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int w);
        logic [63:0] mask, a, b, min, r;
        longint      sa, sb;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        min  = 64'd1 << (w - 1);
        sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb   = b[w-1] ? longint'(b | ~mask) : longint'(b);
        sh   = int'(b % 64'(w));
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd6:  r = a ^ b;
            4'd7:  r = 64'(sa >>> sh);
            4'd8:  r = (a == b) ? 64'd1 : 64'd0;
            4'd9:  r = a * b;
            4'd10: r = (a * b) >> w;
            4'd11: r = (b == 0) ? mask : (a == min && b == mask) ? min : 64'(sa / sb);
            4'd12: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd13: r = (b == 0) ? mask : a / b;
            4'd14: r = (b == 0) ? a : (a == min && b == mask) ? 64'd0 : 64'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r & mask;
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [63:0] a_in,
                                     input logic [63:0] b_in, input int w);
        logic [63:0] mask;
        logic        iter, dz, ovf;
        mask = (64'd1 << w) - 64'd1;
        iter = op inside {4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
        dz   = (op inside {4'd11, 4'd13, 4'd14, 4'd15}) && ((b_in & mask) == 0);
        ovf  = (op inside {4'd11, 4'd14}) && ((a_in & mask) == (64'd1 << (w - 1)))
               && ((b_in & mask) == mask);
        return (iter && !dz && !ovf) ? w + 1 : 1;
    endfunction

    task automatic accept_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        drv_op = op; drv_a = a; drv_b = b; drv_valid = 1'b1;
        n = 0;
        while (!mon_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(mon_ready), 64'd1);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output int bc);
        accept_op(op, a, b);
        lat = 1;
        bc  = 0;
        while (!mon_valid && lat < 100) begin
            if (mon_busy) bc++;
            @(negedge clk);
            lat++;
        end
        res = mon_res;
        drv_rdy = 1'b1;
        @(negedge clk);
        drv_rdy = 1'b0;
        check("idle_after", {62'd0, mon_ready, mon_valid}, 64'd2);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, a, b;
        logic [3:0]  op;
        int          lat, bc, spurious, w, bcount;

        vecs.push_back('{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
        vecs.push_back('{OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1});
        vecs.push_back('{OP_MUL,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33});
        vecs.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vecs.push_back('{OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back('{OP_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{OP_REMU,  32'h00000005, 32'h00000000, 32'h00000005, 1});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1});
        vecs.push_back('{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vecs.push_back('{OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{OP_EQ,    32'h00001234, 32'h00001234, 32'h00000001, 1});
        vecs.push_back('{OP_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1});
        vecs.push_back('{OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 1});
        vecs.push_back('{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        vecs.push_back('{OP_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1});
        vecs.push_back('{OP_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 33});
        vecs.push_back('{OP_REMU,  32'h00000064, 32'h00000007, 32'h00000002, 33});
        vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back('{OP_REM,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{OP_MUL,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(mon_ready), 64'd1);
        check("reset_out_valid", 64'(mon_valid), 64'd0);
        check("reset_busy", 64'(mon_busy), 64'd0);
        check("reset_result", mon_res, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), res, lat, bc);
            check($sformatf("vec%0d_result", i), res, 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), (vecs[i].lat > 1) ? 64'd32 : 64'd0);
        end

        // Back-pressure: result held, in_valid pulses ignored
        accept_op(OP_ADD, 64'd3, 64'd4);
        lat = 0;
        while (!mon_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            drv_valid = i[0];
            drv_op    = OP_SUB;
            drv_a     = 64'(100 + i);
            @(negedge clk);
            check("bp_out_valid", 64'(mon_valid), 64'd1);
            check("bp_result", mon_res, 64'd7);
            check("bp_in_ready", 64'(mon_ready), 64'd0);
        end
        drv_valid = 1'b0;
        drv_rdy   = 1'b1;
        @(negedge clk);
        drv_rdy   = 1'b0;
        spurious = 0;
        repeat (5) begin
            @(negedge clk);
            if (mon_valid || mon_busy) spurious++;
        end
        check("bp_nothing_accepted", 64'(spurious), 64'd0);

        // Flush at BUSY cycle 5
        accept_op(OP_DIV, 64'd1000, 64'd7);
        bcount = 1;
        while (bcount < 5) begin
            @(negedge clk);
            bcount++;
        end
        check("flush_was_busy", 64'(mon_busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_state", {61'd0, mon_ready, mon_valid, mon_busy}, 64'd4);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (mon_valid) spurious++;
        end
        check("flush_no_result", 64'(spurious), 64'd0);

        // Asynchronous reset at BUSY cycle 10
        accept_op(OP_DIV, 64'd1000, 64'd7);
        bcount = 1;
        while (bcount < 10) begin
            @(negedge clk);
            bcount++;
        end
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(mon_ready), 64'd1);
        check("rst_out_valid", 64'(mon_valid), 64'd0);
        check("rst_busy", 64'(mon_busy), 64'd0);
        check("rst_result", mon_res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (mon_valid) spurious++;
        end
        check("rst_no_result", 64'(spurious), 64'd0);
        run_op(OP_DIVU, 64'd1000, 64'd7, res, lat, bc);
        check("post_rst_div", res, 64'd142);

        // Randomized against the model, both widths
        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 1);
            w   = sel ? 16 : 32;
            @(negedge clk);
            if (sel) begin
                run_op(OP_MUL, 64'hFFFF, 64'd2, res, lat, bc);
                check("w16_mul", res, 64'hFFFE);
                check("w16_mul_busy", 64'(bc), 64'd16);
                check("w16_mul_latency", 64'(lat), 64'd17);
            end
            for (int i = 0; i < (sel ? 60 : 200); i++) begin
                op = 4'($urandom_range(0, 15));
                a  = 64'($urandom);
                b  = 64'($urandom);
                case ($urandom_range(0, 7))
                    0: b = 64'd0;
                    1: begin a = 64'd1 << (w - 1); b = '1; end
                    2: b = 64'($urandom_range(0, 40));
                    default: ;
                endcase
                run_op(op, a, b, res, lat, bc);
                check($sformatf("rnd%0d_w%0d_op%0d_result", i, w, op), res, model(op, a, b, w));
                check($sformatf("rnd%0d_w%0d_op%0d_latency", i, w, op), 64'(lat),
                      64'(model_lat(op, a, b, w)));
                check($sformatf("rnd%0d_w%0d_op%0d_busy", i, w, op), 64'(bc),
                      64'(model_lat(op, a, b, w) - 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
